// File: rtl/add_tree_seq_pkg.sv
// add_tree_seq_pkg: shared modes, beat tag and default sizing for the adder-tree sequencer.
package add_tree_seq_pkg;

    localparam int LANES_DEF      = 64;
    localparam int DW_DEF         = 16;
    localparam int TREE_LAT_DEF   = 6;
    localparam int FIFO_DEPTH_DEF = 8;
    localparam int MAX_BEATS_DEF  = 16;

    typedef enum logic [1:0] {
        MODE_16   = 2'b00,
        MODE_32   = 2'b01,
        MODE_64   = 2'b10,
        MODE_LONG = 2'b11
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  last;
    } tag_t;

endpackage

// File: rtl/sum_fifo.sv
// sum_fifo: synchronous result buffer with occupancy count; a pop frees room for a same-cycle push.
module sum_fifo
    import add_tree_seq_pkg::*;
#(
    parameter int W     = 4 * DW_DEF + 3,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && cnt_q != '0;
        do_push = push && (cnt_q != CW'(DEPTH) || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = wdata;
        wr_d  = do_push ? (wr_q == PTR_LAST ? '0 : wr_q + PW'(1)) : wr_q;
        rd_d  = do_pop ? (rd_q == PTR_LAST ? '0 : rd_q + PW'(1)) : rd_q;
        cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign rdata = mem_q[rd_q];
    assign empty = cnt_q == '0;
    assign count = cnt_q;

endmodule

// File: rtl/add_tree_seq.sv
// add_tree_seq: issues beats to the segmented adder tree, tracks them through its latency,
// accumulates long rows and buffers results behind a credit check so the tree never stalls.
module add_tree_seq
    import add_tree_seq_pkg::*;
#(
    parameter int LANES      = LANES_DEF,
    parameter int DW         = DW_DEF,
    parameter int TREE_LAT   = TREE_LAT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF,
    localparam int BW        = $clog2(MAX_BEATS + 1)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          cfg_mode,
    input  logic [BW-1:0]       cfg_beats,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LANES*DW-1:0] in_data,
    output logic                tree_en,
    output logic [1:0]          tree_length_mode,
    output logic                tree_valid_in,
    output logic [LANES*DW-1:0] tree_in_flat,
    input  logic                tree_valid_out,
    input  logic [1:0]          tree_mode_out,
    input  logic [DW-1:0]       tree_sum_64,
    input  logic [DW-1:0]       tree_sum_32_0,
    input  logic [DW-1:0]       tree_sum_32_1,
    input  logic [DW-1:0]       tree_sum_16_0,
    input  logic [DW-1:0]       tree_sum_16_1,
    input  logic [DW-1:0]       tree_sum_16_2,
    input  logic [DW-1:0]       tree_sum_16_3,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DW-1:0]     out_data,
    output logic [2:0]          out_cnt,
    output logic                err_spurious
);

    localparam int IW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = IW + 1;
    localparam int FW = 4 * DW + 3;

    typedef enum logic {IDLE, ROW} state_e;

    state_e                state_q, state_d;
    logic                  run_q;
    logic [BW-1:0]         beat_cnt_q, beat_cnt_d, row_beats_q, row_beats_d;
    logic                  tvalid_q, tvalid_d;
    logic [1:0]            tmode_q, tmode_d;
    logic [LANES*DW-1:0]   tdata_q, tdata_d;
    tag_t                  tag_q, tag_d;
    tag_t                  pipe_q [TREE_LAT];
    tag_t                  pipe_d [TREE_LAT];
    logic [IW-1:0]         inflight_q, inflight_d;
    logic [DW-1:0]         acc_q, acc_d;
    logic                  err_q, err_d;

    logic                  accept, last, ret, push;
    mode_e                 cur_mode;
    logic [BW-1:0]         beats;
    tag_t                  rtag;
    logic [DW-1:0]         sum_long;
    logic [FW-1:0]         wdata, fifo_rdata;
    logic [IW-1:0]         fifo_cnt;
    logic                  fifo_empty;
    logic                  unused_mode;

    always_comb begin
        accept   = in_valid && in_ready;
        cur_mode = state_q == ROW ? MODE_LONG : mode_e'(cfg_mode);
        beats    = cfg_beats == '0 ? BW'(1) : cfg_beats;
        last     = state_q == ROW ? beat_cnt_q + BW'(1) == row_beats_q
                                  : cur_mode != MODE_LONG || beats == BW'(1);
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        row_beats_d = row_beats_q;
        tag_d       = tag_q;
        if (accept) begin
            state_d     = last ? IDLE : ROW;
            beat_cnt_d  = last ? '0 : beat_cnt_q + BW'(1);
            row_beats_d = state_q == IDLE ? beats : row_beats_q;
            tag_d.mode  = cur_mode;
            tag_d.last  = last;
        end
        tvalid_d = accept;
        tdata_d  = accept ? in_data : tdata_q;
        tmode_d  = accept ? (cur_mode == MODE_LONG ? MODE_64 : cur_mode) : tmode_q;
        // The tag rides one stage behind tree_valid_in so its tail lines up with tree_valid_out.
        pipe_d[0] = tag_q;
        for (int i = 1; i < TREE_LAT; i++) pipe_d[i] = pipe_q[i-1];
        rtag     = pipe_q[TREE_LAT-1];
        ret      = tree_valid_out && inflight_q != '0;
        push     = ret && (rtag.mode != MODE_LONG || rtag.last);
        sum_long = acc_q + tree_sum_64;
        acc_d    = ret && rtag.mode == MODE_LONG ? (rtag.last ? '0 : sum_long) : acc_q;
        wdata    = rtag.mode == MODE_16 ? {3'd4, tree_sum_16_3, tree_sum_16_2, tree_sum_16_1, tree_sum_16_0}
                 : rtag.mode == MODE_32 ? {3'd2, {(2*DW){1'b0}}, tree_sum_32_1, tree_sum_32_0}
                 : {3'd1, {(3*DW){1'b0}}, rtag.mode == MODE_LONG ? sum_long : tree_sum_64};
        inflight_d = inflight_q + IW'(accept) - IW'(ret);
        err_d      = err_q || (tree_valid_out && inflight_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            beat_cnt_q  <= '0;
            row_beats_q <= '0;
            tvalid_q    <= 1'b0;
            tmode_q     <= '0;
            tdata_q     <= '0;
            tag_q       <= '0;
            for (int i = 0; i < TREE_LAT; i++) pipe_q[i] <= '0;
            inflight_q  <= '0;
            acc_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= 1'b1;
            beat_cnt_q  <= beat_cnt_d;
            row_beats_q <= row_beats_d;
            tvalid_q    <= tvalid_d;
            tmode_q     <= tmode_d;
            tdata_q     <= tdata_d;
            tag_q       <= tag_d;
            pipe_q      <= pipe_d;
            inflight_q  <= inflight_d;
            acc_q       <= acc_d;
            err_q       <= err_d;
        end
    end

    // Every beat in flight reserves a buffer slot, so a return always finds room.
    assign in_ready = run_q && (SW'(inflight_q) + SW'(fifo_cnt) < SW'(FIFO_DEPTH));

    sum_fifo #(.W(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (out_ready),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign tree_en          = rst_n;
    assign tree_valid_in    = tvalid_q;
    assign tree_length_mode = tmode_q;
    assign tree_in_flat     = tdata_q;
    assign out_valid        = !fifo_empty;
    assign out_data         = fifo_rdata[4*DW-1:0];
    assign out_cnt          = fifo_rdata[FW-1 -: 3];
    assign err_spurious     = err_q;
    assign unused_mode      = ^tree_mode_out;

endmodule
